// File: rtl/letter_entry_ctrl.sv
// Command sequencer for the letter buffer: debounces buttons and tilt, arbitrates
// events, owns the cursor and issues one valid/ready write per accepted command.

module letter_entry_debounce #(
  parameter int          W      = 1,
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] clean
);
  logic [W-1:0] sync1_reg, sync2_reg, filt_reg;
  logic [15:0]  cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      filt_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Accept on the CYCLES-th consecutive cycle of disagreement.
      if (sync2_reg != filt_reg) begin
        if (cnt_reg == CYCLES - 16'd1) begin
          filt_reg <= sync2_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign clean = filt_reg;
endmodule

module letter_entry_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          NUM_SLOTS       = 3,
  parameter bit          AUTO_ADVANCE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_en,
  input  logic                 btn_del,
  input  logic [1:0]           tilt_raw,
  input  logic [5:0]           switch_input,
  input  logic                 wr_ready,
  output logic                 wr_valid,
  output logic [1:0]           wr_slot,
  output logic [5:0]           wr_data,
  output logic [1:0]           cursor,
  output logic [NUM_SLOTS-1:0] slot_full,
  output logic                 err
);
  localparam logic [1:0] LAST_SLOT = 2'(NUM_SLOTS - 1);
  localparam logic [5:0] CLEAR_CODE = 6'h3F;

  typedef enum logic {IDLE, WRITE} state_t;
  typedef enum logic [1:0] {OP_ENTER, OP_CLEAR, OP_BACK} op_t;

  logic       en_filt, del_filt;
  logic [1:0] tilt_filt, tilt_mapped;
  logic       en_prev_reg, del_prev_reg;
  logic [1:0] tilt_prev_reg;
  logic       ev_en, ev_del, ev_l, ev_r;

  state_t                 state_reg, state_next;
  op_t                    op_reg, op_next;
  logic [1:0]             slot_reg, slot_next;
  logic [5:0]             data_reg, data_next;
  logic [1:0]             cursor_reg, cursor_next;
  logic [NUM_SLOTS-1:0]   full_reg, full_next;
  logic                   err_reg, err_next;
  logic                   full_at_cursor;

  assign tilt_mapped = (tilt_raw == 2'b11) ? 2'b00 : tilt_raw;

  letter_entry_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_en (
    .clk(clk), .rst(rst), .raw(btn_en), .clean(en_filt)
  );
  letter_entry_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_del (
    .clk(clk), .rst(rst), .raw(btn_del), .clean(del_filt)
  );
  letter_entry_debounce #(.W(2), .CYCLES(DEBOUNCE_CYCLES)) u_db_tilt (
    .clk(clk), .rst(rst), .raw(tilt_mapped), .clean(tilt_filt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_prev_reg   <= 1'b0;
      del_prev_reg  <= 1'b0;
      tilt_prev_reg <= 2'b00;
    end else begin
      en_prev_reg   <= en_filt;
      del_prev_reg  <= del_filt;
      tilt_prev_reg <= tilt_filt;
    end
  end

  assign ev_en  = en_filt & ~en_prev_reg;
  assign ev_del = del_filt & ~del_prev_reg;
  assign ev_l   = (tilt_filt == 2'b01) && (tilt_prev_reg != 2'b01);
  assign ev_r   = (tilt_filt == 2'b10) && (tilt_prev_reg != 2'b10);

  assign full_at_cursor = full_reg[cursor_reg];

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    slot_next   = slot_reg;
    data_next   = data_reg;
    cursor_next = cursor_reg;
    full_next   = full_reg;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Fixed priority DEL > EN > L > R; losers in the same cycle are dropped.
        if (ev_del) begin
          if (full_at_cursor) begin
            op_next    = OP_CLEAR;
            slot_next  = cursor_reg;
            data_next  = CLEAR_CODE;
            state_next = WRITE;
          end else if (AUTO_ADVANCE && (cursor_reg != 2'd0)) begin
            op_next    = OP_BACK;
            slot_next  = cursor_reg - 2'd1;
            data_next  = CLEAR_CODE;
            state_next = WRITE;
          end
        end else if (ev_en) begin
          if (switch_input <= 6'd25) begin
            op_next    = OP_ENTER;
            slot_next  = cursor_reg;
            data_next  = switch_input;
            state_next = WRITE;
          end else begin
            err_next = 1'b1;
          end
        end else if (ev_l) begin
          if (cursor_reg != 2'd0) cursor_next = cursor_reg - 2'd1;
        end else if (ev_r) begin
          if (cursor_reg != LAST_SLOT) cursor_next = cursor_reg + 2'd1;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          full_next[slot_reg] = (op_reg == OP_ENTER);
          if (op_reg == OP_ENTER && AUTO_ADVANCE && cursor_reg != LAST_SLOT)
            cursor_next = cursor_reg + 2'd1;
          else if (op_reg == OP_BACK)
            cursor_next = cursor_reg - 2'd1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      op_reg     <= OP_ENTER;
      slot_reg   <= 2'd0;
      data_reg   <= CLEAR_CODE;
      cursor_reg <= 2'd0;
      full_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      slot_reg   <= slot_next;
      data_reg   <= data_next;
      cursor_reg <= cursor_next;
      full_reg   <= full_next;
      err_reg    <= err_next;
    end
  end

  assign wr_valid  = (state_reg == WRITE);
  assign wr_slot   = slot_reg;
  assign wr_data   = data_reg;
  assign cursor    = cursor_reg;
  assign slot_full = full_reg;
  assign err       = err_reg;
endmodule

// File: tb/tb_letter_entry_ctrl.sv
// Directed bench for letter_entry_ctrl: a command table plus hand-written
// sequences for bounce, backpressure, tilt and mid-write reset.

module tb_letter_entry_ctrl;
  localparam int HOLD = 12;
  localparam int K_EN = 0, K_DEL = 1, K_L = 2, K_R = 3, K_BOTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_en = 1'b0, btn_del = 1'b0;
  logic [1:0] tilt_raw = 2'b00;
  logic [5:0] switch_input = 6'd0;
  logic       wr_ready = 1'b1;
  logic       wr_valid, err;
  logic [1:0] wr_slot, cursor;
  logic [5:0] wr_data;
  logic [2:0] slot_full;

  letter_entry_ctrl #(.DEBOUNCE_CYCLES(16'd4), .NUM_SLOTS(3), .AUTO_ADVANCE(1'b1)) dut (
    .clk(clk), .rst(rst), .btn_en(btn_en), .btn_del(btn_del), .tilt_raw(tilt_raw),
    .switch_input(switch_input), .wr_ready(wr_ready), .wr_valid(wr_valid),
    .wr_slot(wr_slot), .wr_data(wr_data), .cursor(cursor), .slot_full(slot_full), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int wr_count = 0, err_count = 0, last_slot = -1, last_data = -1;

  // wr_ready only changes just after posedge, so the negedge view predicts the handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_valid && wr_ready) begin
        wr_count++;
        last_slot = int'(wr_slot);
        last_data = int'(wr_data);
      end
      if (err) err_count++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 wr_ready = v;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b0;
    btn_en = 1'b0; btn_del = 1'b0; tilt_raw = 2'b00; switch_input = 6'd0;
    set_ready(rdy);
    step(3);
    chk("rst_wr_valid", int'(wr_valid), 0);
    chk("rst_wr_slot", int'(wr_slot), 0);
    chk("rst_wr_data", int'(wr_data), 63);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_slot_full", int'(slot_full), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    step(2);
  endtask

  task automatic press(input int kind, input int sw);
    switch_input = sw[5:0];
    case (kind)
      K_EN:    btn_en = 1'b1;
      K_DEL:   btn_del = 1'b1;
      K_L:     tilt_raw = 2'b01;
      K_R:     tilt_raw = 2'b10;
      default: begin btn_en = 1'b1; btn_del = 1'b1; end
    endcase
    step(HOLD);
    btn_en = 1'b0; btn_del = 1'b0; tilt_raw = 2'b00;
    step(HOLD);
  endtask

  task automatic wait_valid(input string name);
    int seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (wr_valid) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  typedef struct {
    int kind; int sw;
    int wr; int slot; int data; int cur; int full; int err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int w0, e0;
    vecs[0]  = '{K_EN,   1, 1, 0,  1, 1, 3'b001, 0};
    vecs[1]  = '{K_EN,   2, 1, 1,  2, 2, 3'b011, 0};
    vecs[2]  = '{K_EN,   3, 1, 2,  3, 2, 3'b111, 0};
    vecs[3]  = '{K_EN,   4, 1, 2,  4, 2, 3'b111, 0};
    vecs[4]  = '{K_DEL,  0, 1, 2, 63, 2, 3'b011, 0};
    vecs[5]  = '{K_DEL,  0, 1, 1, 63, 1, 3'b001, 0};
    vecs[6]  = '{K_EN,  30, 0, 0,  0, 1, 3'b001, 1};
    vecs[7]  = '{K_L,    0, 0, 0,  0, 0, 3'b001, 0};
    vecs[8]  = '{K_L,    0, 0, 0,  0, 0, 3'b001, 0};
    vecs[9]  = '{K_DEL,  0, 1, 0, 63, 0, 3'b000, 0};
    vecs[10] = '{K_DEL,  0, 0, 0,  0, 0, 3'b000, 0};
    vecs[11] = '{K_R,    0, 0, 0,  0, 1, 3'b000, 0};
    vecs[12] = '{K_R,    0, 0, 0,  0, 2, 3'b000, 0};
    vecs[13] = '{K_R,    0, 0, 0,  0, 2, 3'b000, 0};
    vecs[14] = '{K_EN,  25, 1, 2, 25, 2, 3'b100, 0};
    vecs[15] = '{K_DEL,  0, 1, 2, 63, 2, 3'b000, 0};
    vecs[16] = '{K_DEL,  0, 1, 1, 63, 1, 3'b000, 0};
    vecs[17] = '{K_EN,   3, 1, 1,  3, 2, 3'b010, 0};
    vecs[18] = '{K_L,    0, 0, 0,  0, 1, 3'b010, 0};
    vecs[19] = '{K_BOTH, 0, 1, 1, 63, 1, 3'b000, 0};

    // Bounce rejection: 2-cycle toggles never survive a 4-cycle filter.
    do_reset(1'b1);
    switch_input = 6'd5;
    w0 = wr_count;
    for (int i = 0; i < 10; i++) begin
      btn_en = ~btn_en;
      step(2);
    end
    chk("bounce_no_write", wr_count - w0, 0);
    btn_en = 1'b1; step(10);
    btn_en = 1'b0; step(HOLD);
    chk("bounce_writes", wr_count - w0, 1);
    chk("bounce_slot", last_slot, 0);
    chk("bounce_data", last_data, 5);
    chk("bounce_cursor", int'(cursor), 1);
    $display("bounce: writes=%0d slot=%0d data=%0d cursor=%0d", wr_count - w0, last_slot, last_data, cursor);

    // Command table.
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      w0 = wr_count; e0 = err_count;
      press(vecs[i].kind, vecs[i].sw);
      chk($sformatf("vec%0d_writes", i), wr_count - w0, vecs[i].wr);
      if (vecs[i].wr != 0) begin
        chk($sformatf("vec%0d_slot", i), last_slot, vecs[i].slot);
        chk($sformatf("vec%0d_data", i), last_data, vecs[i].data);
      end
      chk($sformatf("vec%0d_cursor", i), int'(cursor), vecs[i].cur);
      chk($sformatf("vec%0d_full", i), int'(slot_full), vecs[i].full);
      chk($sformatf("vec%0d_err", i), err_count - e0, vecs[i].err);
      $display("vec%0d kind=%0d sw=%0d writes=%0d cursor=%0d full=%b errs=%0d",
               i, vecs[i].kind, vecs[i].sw, wr_count - w0, cursor, slot_full, err_count - e0);
    end

    // Tilt sequence; 11 must behave as neutral.
    do_reset(1'b1);
    begin
      logic [1:0] tilts [7];
      int         curs  [7];
      tilts = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
      curs  = '{1, 1, 2, 2, 1, 1, 0};
      for (int i = 0; i < 7; i++) begin
        tilt_raw = tilts[i];
        step(HOLD);
        chk($sformatf("tilt%0d_cursor", i), int'(cursor), curs[i]);
        $display("tilt%0d code=%b cursor=%0d", i, tilts[i], cursor);
      end
      tilt_raw = 2'b00;
      step(HOLD);
    end

    // Backpressure: request must stay frozen while wr_ready is low.
    do_reset(1'b0);
    w0 = wr_count;
    switch_input = 6'd7;
    btn_en = 1'b1;
    wait_valid("bp_valid_seen");
    switch_input = 6'd9;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(wr_valid), 1);
      chk("bp_slot", int'(wr_slot), 0);
      chk("bp_data", int'(wr_data), 7);
      chk("bp_cursor", int'(cursor), 0);
      chk("bp_full", int'(slot_full), 0);
    end
    set_ready(1'b1);
    step(2);
    chk("bp_valid_drop", int'(wr_valid), 0);
    chk("bp_writes", wr_count - w0, 1);
    chk("bp_last_data", last_data, 7);
    chk("bp_cursor_after", int'(cursor), 1);
    chk("bp_full_after", int'(slot_full), 1);
    btn_en = 1'b0;
    step(HOLD);
    $display("backpressure: writes=%0d data=%0d cursor=%0d full=%b", wr_count - w0, last_data, cursor, slot_full);

    // Reset during a pending write drops it.
    do_reset(1'b0);
    switch_input = 6'd8;
    btn_en = 1'b1;
    wait_valid("rw_valid_seen");
    rst = 1'b0;
    @(negedge clk);
    chk("rw_wr_valid", int'(wr_valid), 0);
    chk("rw_wr_slot", int'(wr_slot), 0);
    chk("rw_wr_data", int'(wr_data), 63);
    chk("rw_cursor", int'(cursor), 0);
    chk("rw_full", int'(slot_full), 0);
    chk("rw_err", int'(err), 0);
    btn_en = 1'b0;
    step(4);
    w0 = wr_count;
    rst = 1'b1;
    set_ready(1'b1);
    step(20);
    chk("rw_no_write", wr_count - w0, 0);
    $display("reset_mid_write: valid=%0d cursor=%0d writes_after=%0d", wr_valid, cursor, wr_count - w0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
